// File: rtl/trig_capture_ctrl_pkg.sv
// trig_capture_ctrl_pkg: capture FSM state encoding and trigger edge constants
package trig_capture_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, READ} state_t;
  localparam logic EDGE_RISE = 1'b1;
  localparam logic EDGE_FALL = 1'b0;
endpackage

// File: rtl/trig_capture_ctrl_trig_detect.sv
// trig_detect: remembers the previous strobed sample and flags a threshold crossing
module trig_detect
  import trig_capture_ctrl_pkg::*;
#(
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              upd,
  input  logic              trig_edge,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [DATA_W-1:0] sample_data,
  output logic              hit
);
  logic [DATA_W-1:0] prev;
  logic              loaded;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev   <= '0;
      loaded <= 1'b0;
    end else begin
      if (upd) prev <= sample_data;
      loaded <= clr ? 1'b0 : (loaded | upd);
    end
  end
  assign hit = loaded &
    (((trig_edge == EDGE_RISE) & (prev < trig_level) & (sample_data >= trig_level)) |
     ((trig_edge == EDGE_FALL) & (prev >= trig_level) & (sample_data < trig_level)));
endmodule

// File: rtl/trig_capture_ctrl.sv
// trig_capture_ctrl: pre/post-trigger capture into an external circular buffer, then readout
module trig_capture_ctrl
  import trig_capture_ctrl_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic              force_trig,
  input  logic              trig_edge,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [ADDR_W-1:0] pre_len,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              rd_req,
  output logic              buf_wr_en,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] buf_rd_addr,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              busy,
  output logic              triggered,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr
);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  state_t            state, state_nx;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, p_reg, p_arm, start_addr;
  logic [ADDR_W:0]   cnt, post_total;
  logic              hit, trig, post_done, rd_fin;
  trig_detect #(.DATA_W(DATA_W)) u_det (
    .clk         (clk),
    .rst         (rst),
    .clr         (state == IDLE),
    .upd         (buf_wr_en),
    .trig_edge   (trig_edge),
    .trig_level  (trig_level),
    .sample_data (sample_data),
    .hit         (hit)
  );
  assign p_arm       = ({1'b0, pre_len} > DEPTH_X - 1'b1) ? LAST : pre_len;
  assign post_total  = DEPTH_X - {1'b0, p_reg};
  assign post_done   = cnt >= post_total;
  assign trig        = ~abort & (state == WAIT) & sample_en & (force_trig | hit);
  assign rd_fin      = cnt == DEPTH_X - 1'b1;
  assign start_addr  = (trig_addr >= p_reg) ? trig_addr - p_reg
                     : ADDR_W'({1'b0, trig_addr} + DEPTH_X - {1'b0, p_reg});
  assign buf_wr_addr = wr_ptr;
  assign buf_rd_addr = rd_ptr;
  assign busy        = state != IDLE;
  assign done        = state == READ;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end
  always_comb begin
    state_nx  = state;
    buf_wr_en = 1'b0;
    buf_rd_en = 1'b0;
    if (abort) state_nx = IDLE;
    else begin
      case (state)
        IDLE: if (arm) state_nx = (p_arm == '0) ? WAIT : PRE;
        PRE: begin
          buf_wr_en = sample_en;
          if (sample_en && cnt + 1'b1 == {1'b0, p_reg}) state_nx = WAIT;
        end
        WAIT: begin
          buf_wr_en = sample_en;
          if (trig) state_nx = POST;
        end
        POST: begin
          // a full buffer (trigger was the only post sample) must not overwrite the oldest word
          buf_wr_en = sample_en & ~post_done;
          if (post_done || (sample_en && cnt + 1'b1 == post_total)) state_nx = READ;
        end
        READ: begin
          buf_rd_en = rd_req;
          if (rd_req && rd_fin) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      p_reg     <= '0;
      trig_addr <= '0;
      triggered <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
    end else begin
      rd_valid  <= buf_rd_en;
      rd_last   <= buf_rd_en & rd_fin;
      triggered <= (state_nx != IDLE) & (triggered | trig);
      if (buf_wr_en) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (buf_rd_en) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      if (state == IDLE && arm && !abort) begin
        wr_ptr <= '0;
        cnt    <= '0;
        p_reg  <= p_arm;
      end else if (trig) begin
        trig_addr <= wr_ptr;
        cnt       <= (ADDR_W+1)'(1);
      end else if (state_nx == READ && state != READ) begin
        rd_ptr <= start_addr;
        cnt    <= '0;
      end else if (buf_wr_en | buf_rd_en) cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: doc/trig_capture_ctrl.md
TRIG_CAPTURE_CTRL -- requirements
Module: trig_capture_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 12, sample width.
REQ-002 SHALL have parameter ADDR_W, default 10, buffer address width.
REQ-003 SHALL have parameter DEPTH, default 1000, used buffer words; DEPTH <= 2^ADDR_W.
REQ-004 SHALL have ports, one per line, clock and reset first:
  clk  in  1  single clock for all logic.
  rst  in  1  asynchronous, active-high reset.
  arm  in  1  one-cycle start of a capture.
  abort  in  1  return to IDLE from any state.
  force_trig  in  1  trigger regardless of data.
  trig_edge  in  1  trigger edge: 1 = rising, 0 = falling.
  trig_level  in  DATA_W  unsigned trigger threshold.
  pre_len  in  ADDR_W  pre-trigger sample count.
  sample_en  in  1  sample strobe.
  sample_data  in  DATA_W  unsigned sample.
  rd_req  in  1  request one readout word.
  buf_wr_en  out  1  circular-buffer write enable.
  buf_wr_addr  out  ADDR_W  write address.
  buf_rd_en  out  1  buffer read enable; RAM latency is 1 cycle.
  buf_rd_addr  out  ADDR_W  read address.
  rd_valid  out  1  buffer output valid, one cycle after buf_rd_en.
  rd_last  out  1  qualifies the final rd_valid of a readout.
  busy  out  1  high in every state except IDLE.
  triggered  out  1  high from trigger until return to IDLE.
  done  out  1  high in READ.
  trig_addr  out  ADDR_W  address of the trigger sample.

Function
REQ-005 SHALL implement the FSM states IDLE, PRE, WAIT, POST and READ.
REQ-006 IDLE->PRE on arm; arm outside IDLE SHALL be ignored.
REQ-007 Effective pre-trigger count SHALL be P = min(pre_len, DEPTH-1); if P = 0, arm SHALL go directly to WAIT.
REQ-008 In PRE, WAIT and POST, buf_wr_en SHALL equal sample_en (combinational), with buf_wr_addr = write pointer.
REQ-009 Write pointer SHALL advance by 1 per write and wrap DEPTH-1 -> 0.
REQ-010 Write pointer SHALL be 0 at entry to PRE.
REQ-011 PRE SHALL count P writes, then enter WAIT.
REQ-012 WAIT SHALL keep writing and wrapping, and trigger on a qualified sample.
REQ-013 Rising trigger SHALL be prev < trig_level and sample_data >= trig_level; falling trigger is the mirror.
REQ-014 prev SHALL be the last sample_data seen with sample_en; it is updated in PRE, WAIT and POST.
REQ-015 The edge test SHALL be valid only once prev has been loaded since arm.
REQ-016 force_trig SHALL act as a trigger in WAIT only when coincident with sample_en.
REQ-017 On a trigger, the trigger sample SHALL be written, trig_addr SHALL latch its address, triggered SHALL set, and the FSM SHALL enter POST.
REQ-018 The trigger sample SHALL count as post-sample 1.
REQ-019 POST SHALL take DEPTH-P samples total, then enter READ.
REQ-020 READ SHALL set its start address S = (trig_addr - P) mod DEPTH.
REQ-021 In READ, each rd_req SHALL pulse buf_rd_en with buf_rd_addr = read pointer, then advance the pointer with wrap DEPTH-1 -> 0.
REQ-022 After DEPTH reads the FSM SHALL enter IDLE; further rd_req SHALL be ignored.
REQ-023 rd_req outside READ SHALL be ignored.
REQ-024 rd_valid SHALL be buf_rd_en delayed 1 cycle; rd_last SHALL be high with the DEPTH-th rd_valid.
REQ-025 abort SHALL take priority over every other input: the FSM SHALL enter IDLE next cycle, no write or read is issued that cycle, and triggered clears.
REQ-026 A trigger in the cycle that PRE completes SHALL NOT be recognised; triggering starts in WAIT.

Reset
REQ-027 On rst the FSM SHALL be IDLE.
REQ-028 On rst, pointers, trig_addr and prev SHALL be 0.
REQ-029 On rst, all enables and flags (buf_wr_en, buf_rd_en, rd_valid, rd_last, busy, triggered, done) SHALL be 0.
REQ-030 Reset mid-capture or mid-readout SHALL discard the operation with no further buffer accesses.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding and the trig_edge constants.
REQ-032 One sub-module, trig_detect, SHALL hold prev, the loaded flag and the edge compare.
REQ-033 The buffer RAM SHALL be external and is not part of this block.

Verification
REQ-034 DEPTH=16, P=4: ramp 0..; rising at level 10 -> trig_addr=10, 16 reads yield 6..21, rd_last on value 21.
REQ-035 Falling edge: data 20,20,5 with level 10 -> trigger on the sample 5; a sample equal to level with no crossing -> no trigger.
REQ-036 pre_len=40, DEPTH=16 -> P clamps to 15; force_trig in WAIT -> POST of 1 sample, then READ.
REQ-037 Long WAIT (write pointer wraps twice before trigger) -> readout start S is correct modulo DEPTH.
REQ-038 abort in POST -> IDLE next cycle, no buf_wr_en that cycle, triggered=0; arm during READ -> ignored.
REQ-039 rst asserted mid-READ -> all outputs 0 at once; a subsequent arm runs a full capture correctly.
